// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: shared types and defaults for the zeroheti OBI infrastructure.
//   mgr_idx_e         : manager index (core data port, debug SBA port)
//   arb_state_e       : arbiter lock state
//   ObiMaxOutstanding : default outstanding-transaction budget
package zeroheti_pkg;

   typedef enum logic {
      MGR_CORE = 1'b0,
      MGR_SBA  = 1'b1
   } mgr_idx_e;

   typedef enum logic {
      StIdle   = 1'b0,
      StLocked = 1'b1
   } arb_state_e;

   localparam int unsigned ObiMaxOutstanding = 2;

endpackage

// File: rtl/zeroheti_obi_arb2_if.sv
// zeroheti_obi_arb2_if: bundle of both OBI manager ports and the subordinate port of the
// 2-to-1 arbiter. Signal suffixes are from the arbiter's point of view.
//   m0_* : core data manager      m1_* : debug SBA manager     sbr_* : system-bus subordinate
// Modports:
//   slave  : arbiter side (accepts manager requests, drives the subordinate)
//   master : environment side (managers and subordinate models)
interface zeroheti_obi_arb2_if #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
);
   localparam int unsigned BeWidth = DataWidth / 8;

   logic                 m0_req_i,    m1_req_i;
   logic                 m0_gnt_o,    m1_gnt_o;
   logic [AddrWidth-1:0] m0_addr_i,   m1_addr_i;
   logic                 m0_we_i,     m1_we_i;
   logic [BeWidth-1:0]   m0_be_i,     m1_be_i;
   logic [DataWidth-1:0] m0_wdata_i,  m1_wdata_i;
   logic                 m0_rvalid_o, m1_rvalid_o;
   logic [DataWidth-1:0] m0_rdata_o,  m1_rdata_o;
   logic                 m0_err_o,    m1_err_o;

   logic                 sbr_req_o;
   logic [AddrWidth-1:0] sbr_addr_o;
   logic                 sbr_we_o;
   logic [BeWidth-1:0]   sbr_be_o;
   logic [DataWidth-1:0] sbr_wdata_o;
   logic                 sbr_gnt_i;
   logic                 sbr_rvalid_i;
   logic [DataWidth-1:0] sbr_rdata_i;
   logic                 sbr_err_i;

   modport slave (
      input  m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      input  m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      output sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
      input  sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
   );

   modport master (
      output m0_req_i, m0_addr_i, m0_we_i, m0_be_i, m0_wdata_i,
      output m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      input  sbr_req_o, sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o,
      output sbr_gnt_i, sbr_rvalid_i, sbr_rdata_i, sbr_err_i
   );

endinterface

// File: rtl/zeroheti_rsp_fifo.sv
// zeroheti_rsp_fifo: small FIFO recording which manager issued each outstanding request.
//   i_clk, i_rst (async, active-high)
//   i_push / i_data : enqueue (ignored when full)
//   i_pop           : dequeue head (ignored when empty)
//   o_data          : head entry
//   o_full, o_empty, o_count : occupancy
module zeroheti_rsp_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [Width-1:0]           i_data,
   input  logic                       i_pop,
   output logic [Width-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(Depth+1)-1:0] o_count
);
   localparam int unsigned CntWidth = $clog2(Depth + 1);
   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0]    r_mem [Depth];
   logic [PtrWidth-1:0] r_wptr, r_rptr;
   logic [CntWidth-1:0] r_count;
   logic                w_push, w_pop;

   // Explicit wrap keeps Depth == 1 correct (pointer pinned to 0).
   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   assign o_full  = (r_count == CntWidth'(Depth));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         if (w_push && !w_pop)      r_count <= r_count + CntWidth'(1);
         else if (w_pop && !w_push) r_count <= r_count - CntWidth'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/zeroheti_obi_arb2.sv
// zeroheti_obi_arb2: 2-to-1 OBI request arbiter in front of the system-bus subordinate.
//   clk_i, rst_i (async, active-high)
//   bus          : zeroheti_obi_arb2_if.slave (m0 = core, m1 = debug SBA, sbr = subordinate)
//   rsp_orphan_o : sticky, a response arrived with nothing outstanding (cleared by reset only)
// Fixed priority m0 > m1 by default; define ZEROHETI_ARB_RR_EN for round-robin.
// An ungranted request locks the selection so the address phase stays stable.
// Responses are in order and routed by a FIFO of issuing-manager indices.
module zeroheti_obi_arb2
   import zeroheti_pkg::*;
#(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = ObiMaxOutstanding
) (
   input  logic               clk_i,
   input  logic               rst_i,
   zeroheti_obi_arb2_if.slave bus,
   output logic               rsp_orphan_o
);
   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

   arb_state_e           r_state, w_state_d;
   mgr_idx_e             r_sel, w_sel_d, w_sel;
   logic                 w_sel_req, w_sbr_req, w_accept;
   logic                 w_full, w_empty, w_pop;
   logic [0:0]           w_head;
   logic [CntWidth-1:0]  w_count;
   logic                 r_orphan;
   logic [AddrWidth-1:0] w_addr;
   logic                 w_we;
   logic [BeWidth-1:0]   w_be;
   logic [DataWidth-1:0] w_wdata;
`ifdef ZEROHETI_ARB_RR_EN
   mgr_idx_e             r_rr;
`endif

   // Selection: held while locked, otherwise recomputed from current requests.
   always_comb begin
      w_sel = MGR_CORE;
      if (r_state == StLocked) begin
         w_sel = r_sel;
      end else if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef ZEROHETI_ARB_RR_EN
         w_sel = r_rr;
`else
         w_sel = MGR_CORE;
`endif
      end else if (bus.m1_req_i) begin
         w_sel = MGR_SBA;
      end
   end

   always_comb begin
      w_sel_req = bus.m0_req_i;
      w_addr    = bus.m0_addr_i;
      w_we      = bus.m0_we_i;
      w_be      = bus.m0_be_i;
      w_wdata   = bus.m0_wdata_i;
      if (w_sel == MGR_SBA) begin
         w_sel_req = bus.m1_req_i;
         w_addr    = bus.m1_addr_i;
         w_we      = bus.m1_we_i;
         w_be      = bus.m1_be_i;
         w_wdata   = bus.m1_wdata_i;
      end
   end

   // Full blocks the request outright; a same-cycle pop does not free a slot.
   // Gating with rst_i keeps the combinational outputs quiet while reset is asserted.
   assign w_sbr_req = w_sel_req && !w_full && !rst_i;
   assign w_accept  = w_sbr_req && bus.sbr_gnt_i;

   assign bus.sbr_req_o   = w_sbr_req;
   assign bus.sbr_addr_o  = w_addr;
   assign bus.sbr_we_o    = w_we;
   assign bus.sbr_be_o    = w_be;
   assign bus.sbr_wdata_o = w_wdata;
   assign bus.m0_gnt_o    = w_accept && (w_sel == MGR_CORE);
   assign bus.m1_gnt_o    = w_accept && (w_sel == MGR_SBA);

   always_comb begin
      w_state_d = r_state;
      w_sel_d   = r_sel;
      case (r_state)
         StIdle: begin
            if (w_sbr_req && !bus.sbr_gnt_i) begin
               w_state_d = StLocked;
               w_sel_d   = w_sel;
            end
         end
         StLocked: begin
            // A full-stall keeps the lock; only accept or a dropped request releases it.
            if (w_accept || !w_sel_req) w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= StIdle;
         r_sel    <= MGR_CORE;
         r_orphan <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_sel    <= w_sel_d;
         r_orphan <= r_orphan || (bus.sbr_rvalid_i && w_empty);
      end
   end

`ifdef ZEROHETI_ARB_RR_EN
   // After every accept the pointer favours the manager that did not win.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr <= MGR_CORE;
      end else if (w_accept) begin
         r_rr <= (w_sel == MGR_CORE) ? MGR_SBA : MGR_CORE;
      end
   end
`endif

   zeroheti_rsp_fifo #(
      .Depth (MaxOutstanding),
      .Width (1)
   ) u_rsp_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_accept),
      .i_data  (w_sel),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Responses with nothing outstanding are dropped (no pop, no manager rvalid).
   assign w_pop           = bus.sbr_rvalid_i && !w_empty;
   assign bus.m0_rvalid_o = w_pop && (w_head == 1'b0);
   assign bus.m1_rvalid_o = w_pop && (w_head == 1'b1);
   assign bus.m0_rdata_o  = bus.sbr_rdata_i;
   assign bus.m1_rdata_o  = bus.sbr_rdata_i;
   assign bus.m0_err_o    = bus.sbr_err_i;
   assign bus.m1_err_o    = bus.sbr_err_i;
   assign rsp_orphan_o    = r_orphan;

   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      w_count <= CntWidth'(MaxOutstanding));
   a_full_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
      w_full == (w_count == CntWidth'(MaxOutstanding)));

endmodule

// File: tb/tb_zeroheti_obi_arb2.sv
// tb_zeroheti_obi_arb2: scoreboard bench for zeroheti_obi_arb2.
// A queue-based reference model predicts accepts and responses; expected transactions are
// queued and a separate monitor compares them when the DUT presents grants or rvalids.
// Honours ZEROHETI_ARB_RR_EN for the arbitration rule.
module tb_zeroheti_obi_arb2;
   import zeroheti_pkg::*;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned MaxOut = 2;

   typedef struct {
      int          mgr;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          mgr;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic orphan;

   zeroheti_obi_arb2_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

   zeroheti_obi_arb2 #(
      .AddrWidth      (AW),
      .DataWidth      (DW),
      .MaxOutstanding (MaxOut)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bus          (bus),
      .rsp_orphan_o (orphan)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   req_t exp_gnt[$];
   rsp_t exp_rsp[$];

   // Stimulus state: a manager's request is held until granted.
   logic pend [2];
   req_t preq [2];

   // Reference model state.
   int   m_out[$];
   int   m_lock;
   int   m_rr;
   logic m_orphan;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic new_req(input int m);
      pend[m]       = 1'b1;
      preq[m].mgr   = m;
      preq[m].addr  = $urandom;
      preq[m].we    = 1'($urandom);
      preq[m].be    = 4'($urandom);
      preq[m].wdata = $urandom;
   endtask

   task automatic drive_idle();
      bus.m0_req_i = 1'b0;  bus.m1_req_i = 1'b0;
      bus.m0_addr_i = '0;   bus.m1_addr_i = '0;
      bus.m0_we_i = 1'b0;   bus.m1_we_i = 1'b0;
      bus.m0_be_i = '0;     bus.m1_be_i = '0;
      bus.m0_wdata_i = '0;  bus.m1_wdata_i = '0;
      bus.sbr_gnt_i = 1'b0; bus.sbr_rvalid_i = 1'b0;
      bus.sbr_rdata_i = '0; bus.sbr_err_i = 1'b0;
   endtask

   // One clock of stimulus plus model update.
   task automatic step(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic err);
      int  win;
      bit  full;
      @(negedge clk);
      bus.m0_req_i   = pend[0];       bus.m1_req_i   = pend[1];
      bus.m0_addr_i  = preq[0].addr;  bus.m1_addr_i  = preq[1].addr;
      bus.m0_we_i    = preq[0].we;    bus.m1_we_i    = preq[1].we;
      bus.m0_be_i    = preq[0].be;    bus.m1_be_i    = preq[1].be;
      bus.m0_wdata_i = preq[0].wdata; bus.m1_wdata_i = preq[1].wdata;
      bus.sbr_gnt_i    = gnt;
      bus.sbr_rvalid_i = rv;
      bus.sbr_rdata_i  = rdata;
      bus.sbr_err_i    = err;
      #1;
      check("orphan_flag", orphan, m_orphan);
      full = (m_out.size() >= MaxOut);
      if (m_lock >= 0 && !pend[m_lock]) m_lock = -1;
      win = -1;
      if (!full) begin
         if (m_lock >= 0) win = m_lock;
`ifdef ZEROHETI_ARB_RR_EN
         else if (pend[0] && pend[1]) win = m_rr;
`else
         else if (pend[0] && pend[1]) win = 0;
`endif
         else if (pend[0]) win = 0;
         else if (pend[1]) win = 1;
      end
      check("sbr_req", bus.sbr_req_o, (win >= 0));
      if (win >= 0) check("sbr_addr", bus.sbr_addr_o, preq[win].addr);
      if (rv) begin
         if (m_out.size() > 0) begin
            exp_rsp.push_back('{m_out[0], rdata, err});
            void'(m_out.pop_front());
         end else begin
            m_orphan = 1'b1;
         end
      end
      if (win >= 0) begin
         if (gnt) begin
            exp_gnt.push_back(preq[win]);
            m_out.push_back(win);
            m_lock    = -1;
            m_rr      = 1 - win;
            pend[win] = 1'b0;
         end else begin
            m_lock = win;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (pend[0] || pend[1] || m_out.size() > 0); i++)
         step(1'b1, m_out.size() > 0, $urandom, 1'($urandom));
      check("drain_done", (pend[0] || pend[1] || m_out.size() > 0), 0);
   endtask

   // Reset with busy-looking inputs: every gated output must read 0 while rst is high.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.m0_req_i = 1'b1; bus.m1_req_i = 1'b1;
      bus.sbr_gnt_i = 1'b1; bus.sbr_rvalid_i = 1'b1;
      #1;
      check("rst_m0_gnt", bus.m0_gnt_o, 0);
      check("rst_m1_gnt", bus.m1_gnt_o, 0);
      check("rst_m0_rvalid", bus.m0_rvalid_o, 0);
      check("rst_m1_rvalid", bus.m1_rvalid_o, 0);
      check("rst_sbr_req", bus.sbr_req_o, 0);
      check("rst_orphan", orphan, 0);
      pend[0] = 1'b0; pend[1] = 1'b0;
      m_out.delete();
      m_lock = -1; m_rr = 0; m_orphan = 1'b0;
      @(negedge clk);
      drive_idle();
      rst = 1'b0;
   endtask

   // Monitor: compares DUT-presented grants and responses against queued expectations.
   initial begin
      req_t eg;
      rsp_t er;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (bus.sbr_req_o && bus.sbr_gnt_i) begin
               if (exp_gnt.size() == 0) begin
                  check("unexpected_accept", 1, 0);
               end else begin
                  eg = exp_gnt.pop_front();
                  check("m0_gnt", bus.m0_gnt_o, (eg.mgr == 0));
                  check("m1_gnt", bus.m1_gnt_o, (eg.mgr == 1));
                  check("acc_addr", bus.sbr_addr_o, eg.addr);
                  check("acc_we", bus.sbr_we_o, eg.we);
                  check("acc_be", bus.sbr_be_o, eg.be);
                  check("acc_wdata", bus.sbr_wdata_o, eg.wdata);
               end
            end else begin
               check("gnt_without_accept", {bus.m1_gnt_o, bus.m0_gnt_o}, 0);
            end
            if (bus.m0_rvalid_o || bus.m1_rvalid_o) begin
               check("rvalid_both", (bus.m0_rvalid_o && bus.m1_rvalid_o), 0);
               if (exp_rsp.size() == 0) begin
                  check("unexpected_rvalid", 1, 0);
               end else begin
                  er = exp_rsp.pop_front();
                  check("rsp_mgr", (bus.m1_rvalid_o ? 1 : 0), er.mgr);
                  check("m0_rdata", bus.m0_rdata_o, er.rdata);
                  check("m1_rdata", bus.m1_rdata_o, er.rdata);
                  check("m0_err", bus.m0_err_o, er.err);
                  check("m1_err", bus.m1_err_o, er.err);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      drive_idle();
      pend[0] = 1'b0; pend[1] = 1'b0;
      preq[0] = '{0, 32'h0, 1'b0, 4'h0, 32'h0};
      preq[1] = '{1, 32'h0, 1'b0, 4'h0, 32'h0};
      m_lock = -1; m_rr = 0; m_orphan = 1'b0;
      #1 rst = 1'b1;
      do_reset();

      // m1 alone reads 0x1000, granted at once, response two cycles later.
      pend[1] = 1'b1;
      preq[1] = '{1, 32'h0000_1000, 1'b0, 4'hF, 32'h0};
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      drain();

      // Both managers request every cycle with the subordinate always granting.
      for (int i = 0; i < 8; i++) begin
         if (!pend[0]) new_req(0);
         if (!pend[1]) new_req(1);
         step(1'b1, m_out.size() > 0, $urandom, 1'($urandom));
      end
      drain();

      // m1 stalls three cycles; m0 arrives mid-stall and must not steal the bus.
      new_req(1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      new_req(0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      drain();

      // Fill to the limit, third request blocked, responses err=0 then err=1.
      new_req(0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      new_req(1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      new_req(0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h1111_0000, 1'b0);
      step(1'b1, 1'b1, 32'h2222_0000, 1'b1);
      drain();

      // Push and pop together at occupancy 1, across pointer wrap.
      new_req(0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         new_req((i + 1) % 2);
         step(1'b1, 1'b1, $urandom, 1'($urandom));
      end
      drain();

      // Orphan response, then reset mid-transaction with a late response.
      step(1'b0, 1'b1, 32'hBAD0_0001, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      new_req(0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'hBAD0_0002, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         for (int m = 0; m < 2; m++)
            if (!pend[m] && ($urandom % 10) < 4) new_req(m);
         step(($urandom % 10) < 7, (m_out.size() > 0) && 1'($urandom), $urandom,
              1'($urandom));
      end
      drain();

      @(negedge clk);
      #3;
      check("exp_gnt_left", exp_gnt.size(), 0);
      check("exp_rsp_left", exp_rsp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
